// File: rtl/itrx_aib_phy_jtag_pkg.sv
// Shared encodings for the AIB PHY JTAG master sequencer.
// Holds the opcodes, the FSM states, the TMS header patterns and the TAP reset count.
package itrx_aib_phy_jtag_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'd0,
        OP_IR_SCAN   = 2'd1,
        OP_DR_SCAN   = 2'd2,
        OP_RSVD      = 2'd3   // behaves as TAP_RESET
    } jtag_op_e;

    typedef enum logic [2:0] {
        ST_RST_TAP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_HDR     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_UPD     = 3'd4,
        ST_RTI     = 3'd5
    } seq_state_e;

    // Header TMS patterns, consumed LSB first, taking the TAP from Run-Test/Idle
    // into Shift-IR (1,1,0,0) or Shift-DR (1,0,0).
    localparam logic [3:0] HDR_IR_TMS = 4'b0011;
    localparam logic [2:0] HDR_IR_LEN = 3'd4;
    localparam logic [2:0] HDR_DR_TMS = 3'b001;
    localparam logic [2:0] HDR_DR_LEN = 3'd3;

    // Number of consecutive TMS=1 cycles that force Test-Logic-Reset.
    localparam logic [2:0] RST_TMS_CYC = 3'd5;

endpackage

// File: rtl/itrx_aib_phy_jtag_seq_shreg.sv
// TDI shift-out / TDO capture datapath for the JTAG sequencer.
// Capture runs one edge behind shift, since the TAP consumes a TDI bit (and
// presents the matching TDO bit) on the edge after it is driven.
module itrx_aib_phy_jtag_seq_shreg
    import itrx_aib_phy_jtag_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               tck,
    input  logic               reset,
    input  logic               load,       // accept edge: latch data and clamped length
    input  logic [LEN_W-1:0]   load_len,   // already clamped to 1..MAX_LEN
    input  logic [MAX_LEN-1:0] load_data,
    input  logic               shift_en,   // drive next TDI bit this edge
    input  logic               tdo,
    output logic               tdi_bit,
    output logic               last_bit,   // the bit being driven is the final one
    output logic [MAX_LEN-1:0] cap_data
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [MAX_LEN-1:0] sh_q, sh_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   len_m1_q, len_m1_d;
    logic               cap_pend_q, cap_pend_d;

    // Shift-out, bit count and MSB-inserted capture; bits above L-1 stay zero.
    always_comb begin
        sh_d       = sh_q;
        cap_d      = cap_q;
        cnt_d      = cnt_q;
        len_m1_d   = len_m1_q;
        cap_pend_d = shift_en;
        if (load) begin
            sh_d     = load_data;
            cap_d    = '0;
            cnt_d    = '0;
            len_m1_d = IDX_W'(load_len - LEN_W'(1));
        end else begin
            if (shift_en) begin
                sh_d  = sh_q >> 1;
                cnt_d = cnt_q + IDX_W'(1);
            end
            if (cap_pend_q) begin
                cap_d           = cap_q >> 1;
                cap_d[len_m1_q] = tdo;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge tck) begin
        if (reset) begin
            sh_q       <= '0;
            cap_q      <= '0;
            cnt_q      <= '0;
            len_m1_q   <= '0;
            cap_pend_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            cap_q      <= cap_d;
            cnt_q      <= cnt_d;
            len_m1_q   <= len_m1_d;
            cap_pend_q <= cap_pend_d;
        end
    end

    assign tdi_bit  = sh_q[0];
    assign last_bit = (cnt_q == len_m1_q);
    assign cap_data = cap_q;

endmodule

// File: rtl/itrx_aib_phy_jtag_seq.sv
// On-chip JTAG master sequencer for the AIB PHY TAP.
// Turns TAP_RESET / IR_SCAN / DR_SCAN commands into registered tms/tdi streams
// and returns the captured tdo bits. Optional macro ITRX_AIB_JTAG_SEQ_RTI_WAIT_EN
// adds an rti_wait input that extends the Run-Test/Idle dwell after each scan.
module itrx_aib_phy_jtag_seq
    import itrx_aib_phy_jtag_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               tck,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
`ifdef ITRX_AIB_JTAG_SEQ_RTI_WAIT_EN
    input  logic [7:0]         rti_wait,
`endif
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               busy
);

    seq_state_e         state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;          // RST_TAP / HDR cycle counter
    logic               is_ir_q, is_ir_d;
    logic               rsp_pend_q, rsp_pend_d; // RST_TAP came from a command
    logic [8:0]         rti_cnt_q, rti_cnt_d;
    logic [7:0]         rti_wait_q;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

    logic               sh_load, sh_shift;
    logic               sh_tdi, sh_last;
    logic [MAX_LEN-1:0] sh_cap;
    logic [LEN_W-1:0]   len_clamped;
    logic [3:0]         hdr_tms;
    logic [2:0]         hdr_len;

`ifdef ITRX_AIB_JTAG_SEQ_RTI_WAIT_EN
    logic [7:0] rti_wait_d;
`else
    assign rti_wait_q = 8'd0;
`endif

    // Zero-length scans shift one bit; oversize scans saturate at MAX_LEN.
    always_comb begin
        len_clamped = cmd_len;
        if (cmd_len == '0)
            len_clamped = LEN_W'(1);
        else if (cmd_len > LEN_W'(MAX_LEN))
            len_clamped = LEN_W'(MAX_LEN);
    end

    assign hdr_tms = is_ir_q ? HDR_IR_TMS : {1'b0, HDR_DR_TMS};
    assign hdr_len = is_ir_q ? HDR_IR_LEN : HDR_DR_LEN;

    itrx_aib_phy_jtag_seq_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shreg (
        .tck       (tck),
        .reset     (reset),
        .load      (sh_load),
        .load_len  (len_clamped),
        .load_data (cmd_data),
        .shift_en  (sh_shift),
        .tdo       (tdo),
        .tdi_bit   (sh_tdi),
        .last_bit  (sh_last),
        .cap_data  (sh_cap)
    );

    // State register and registered TAP/response outputs. Reset preloads the
    // TMS-high count with 1 because the reset edge itself already drives tms=1.
    always_ff @(posedge tck) begin
        if (reset) begin
            state_q     <= ST_RST_TAP;
            cnt_q       <= 3'd1;
            is_ir_q     <= 1'b0;
            rsp_pend_q  <= 1'b0;
            rti_cnt_q   <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ITRX_AIB_JTAG_SEQ_RTI_WAIT_EN
            rti_wait_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_ir_q     <= is_ir_d;
            rsp_pend_q  <= rsp_pend_d;
            rti_cnt_q   <= rti_cnt_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ITRX_AIB_JTAG_SEQ_RTI_WAIT_EN
            rti_wait_q  <= rti_wait_d;
`endif
        end
    end

    // Next-state: accept in IDLE, walk header, shift, Update, then RTI dwell.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_ir_d    = is_ir_q;
        rsp_pend_d = rsp_pend_q;
        rti_cnt_d  = rti_cnt_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
`ifdef ITRX_AIB_JTAG_SEQ_RTI_WAIT_EN
        rti_wait_d = rti_wait_q;
`endif
        case (state_q)
            ST_RST_TAP: begin
                // cnt 0..4: tms high, cnt 5: tms low, cnt 6: done
                if (cnt_q > RST_TMS_CYC) begin
                    state_d    = ST_IDLE;
                    rsp_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    sh_load = 1'b1;
                    cnt_d   = 3'd0;
                    is_ir_d = (cmd_op == OP_IR_SCAN);
`ifdef ITRX_AIB_JTAG_SEQ_RTI_WAIT_EN
                    rti_wait_d = rti_wait;
`endif
                    if (cmd_op == OP_IR_SCAN || cmd_op == OP_DR_SCAN) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d    = ST_RST_TAP;
                        rsp_pend_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == hdr_len - 3'd1)
                    state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_shift = 1'b1;
                if (sh_last)
                    state_d = ST_UPD;
            end
            ST_UPD: begin
                // one RTI-drive cycle plus the optional extra dwell
                state_d   = ST_RTI;
                rti_cnt_d = {1'b0, rti_wait_q} + 9'd1;
            end
            ST_RTI: begin
                if (rti_cnt_q == '0)
                    state_d = ST_IDLE;
                else
                    rti_cnt_d = rti_cnt_q - 9'd1;
            end
            default: state_d = ST_RST_TAP;
        endcase
    end

    // Outputs registered on the next edge: tms/tdi per state, response on completion.
    always_comb begin
        tms_d       = 1'b0;
        tdi_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_RST_TAP: begin
                tms_d = (cnt_q < RST_TMS_CYC);
                if (cnt_q > RST_TMS_CYC && rsp_pend_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                end
            end
            ST_HDR: tms_d = hdr_tms[cnt_q[1:0]];
            ST_SHIFT: begin
                tdi_d = sh_tdi;
                tms_d = sh_last;   // last bit moves the TAP to Exit1
            end
            ST_UPD: tms_d = 1'b1;
            ST_RTI: begin
                if (rti_cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = sh_cap;
                end
            end
            default: tms_d = 1'b0;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_itrx_aib_phy_jtag_seq.sv
// Directed bench for itrx_aib_phy_jtag_seq against a behavioural TAP with a
// 15-bit IR (7 effective bits) and an 8-bit DR loopback.
module tb_itrx_aib_phy_jtag_seq;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    localparam int TLR = 0,  RTI = 1,  SDS = 2,  CDR = 3,  SHDR = 4,  E1DR = 5,  PDR = 6,  E2DR = 7;
    localparam int UDR = 8,  SIS = 9,  CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    logic               tck = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op = 2'd0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               cmd_ready, rsp_valid, tms, tdi, tdo, busy;
    logic [MAX_LEN-1:0] rsp_data;
`ifdef ITRX_AIB_JTAG_SEQ_RTI_WAIT_EN
    logic [7:0]         rti_wait = 8'd0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 tck = ~tck;

    itrx_aib_phy_jtag_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .tck       (tck),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
`ifdef ITRX_AIB_JTAG_SEQ_RTI_WAIT_EN
        .rti_wait  (rti_wait),
`endif
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .busy      (busy)
    );

    // ---------------- behavioural TAP ----------------
    int          tap_st = SDS;
    logic [14:0] ir_sr  = '0;
    logic [6:0]  ir     = 7'h01;
    logic [7:0]  dr_sr  = '0;
    logic [7:0]  dr_reg = 8'h3C;
    int          tlr_cnt = 0, shdr_cnt = 0, rsp_cnt = 0;

    function automatic int tap_next(input int st, input logic t);
        case (st)
            TLR:  return t ? TLR  : RTI;
            RTI:  return t ? SDS  : RTI;
            SDS:  return t ? SIS  : CDR;
            CDR:  return t ? E1DR : SHDR;
            SHDR: return t ? E1DR : SHDR;
            E1DR: return t ? UDR  : PDR;
            PDR:  return t ? E2DR : PDR;
            E2DR: return t ? UDR  : SHDR;
            UDR:  return t ? SDS  : RTI;
            SIS:  return t ? TLR  : CIR;
            CIR:  return t ? E1IR : SHIR;
            SHIR: return t ? E1IR : SHIR;
            E1IR: return t ? UIR  : PIR;
            PIR:  return t ? E2IR : PIR;
            E2IR: return t ? UIR  : SHIR;
            default: return t ? SDS : RTI;   // UIR
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            CIR:  ir_sr  <= {8'b0, ir};
            SHIR: ir_sr  <= {tdi, ir_sr[14:1]};
            UIR:  ir     <= ir_sr[6:0];
            CDR:  dr_sr  <= dr_reg;
            SHDR: dr_sr  <= {tdi, dr_sr[7:1]};
            UDR:  dr_reg <= dr_sr;
            default: ;
        endcase
        if (tap_st == TLR)  tlr_cnt  <= tlr_cnt + 1;
        if (tap_st == SHDR) shdr_cnt <= shdr_cnt + 1;
        if (rsp_valid)      rsp_cnt  <= rsp_cnt + 1;
        tap_st <= tap_next(tap_st, tms);
    end

    assign tdo = (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? dr_sr[0] : 1'b0;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one command; lat = edges from accept to rsp_valid (-1 if none).
    task automatic run_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                           input logic [31:0] data, output int lat, output logic [31:0] rd);
        int n;
        lat = -1;
        rd  = '0;
        n   = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge tck);
            n++;
        end
        @(negedge tck);
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        @(posedge tck); #1;
        cmd_valid = 1'b0;
        chk("acc_busy", busy, 1);
        for (int k = 1; k <= 200; k++) begin
            @(posedge tck); #1;
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_data;
                break;
            end
        end
    endtask

    task automatic scan(input string tag, input logic [1:0] op, input logic [LEN_W-1:0] len,
                        input logic [31:0] data, input int exp_lat, input logic [31:0] exp_rd);
        int          lat;
        logic [31:0] rd;
        run_cmd(op, len, data, lat, rd);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rsp"}, rd, exp_rd);
        chk({tag, "_rdy"}, cmd_ready, 1);
        @(posedge tck); #1;
        chk({tag, "_pulse"}, rsp_valid, 0);
        chk({tag, "_hold"}, rsp_data, exp_rd);
        chk({tag, "_tms"}, tms, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          base_rsp, base_tlr, base_sh, lat, n;
        logic [31:0] rd;

        // power-on reset: 3 edges
        @(posedge tck); #1;
        chk("rst_tms", tms, 1);
        chk("rst_tdi", tdi, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 1);
        repeat (2) @(posedge tck);
        @(negedge tck); reset = 1'b0;
        n = 0;
        while (n < 50) begin
            @(posedge tck); #1;
            n++;
            if (cmd_ready) break;
        end
        chk("por_ready_lat", n, 6);
        chk("por_tlr_seen", tlr_cnt > 0, 1);
        chk("por_tap_rti", tap_st, RTI);
        chk("por_no_rsp", rsp_cnt, 0);

        // IR scans: write 0x55, then read it back while writing 0
        scan("ir1", 2'd1, 6'd15, 32'h0000_0055, 22, 32'h0000_0001);
        chk("ir1_instr", ir, 7'h55);
        chk("ir1_tap_rti", tap_st, RTI);
        scan("ir2", 2'd1, 6'd15, 32'h0000_0000, 22, 32'h0000_0055);
        chk("ir2_instr", ir, 7'h00);

        // reset asserted at k = 8 of an IR scan
        base_rsp = rsp_cnt;
        base_tlr = tlr_cnt;
        @(negedge tck);
        cmd_op = 2'd1; cmd_len = 6'd15; cmd_data = 32'h0000_7FFF; cmd_valid = 1'b1;
        @(posedge tck); #1;
        cmd_valid = 1'b0;
        repeat (7) @(posedge tck);
        @(negedge tck); reset = 1'b1;
        @(posedge tck); #1;
        chk("mrst_tms_r", tms, 1);
        chk("mrst_busy", busy, 1);
        @(negedge tck); reset = 1'b0;
        for (int k = 9; k <= 12; k++) begin
            @(posedge tck); #1;
            chk("mrst_tms_hi", tms, 1);
        end
        @(posedge tck); #1;
        chk("mrst_tms_lo", tms, 0);
        @(posedge tck); #1;
        chk("mrst_ready", cmd_ready, 1);
        chk("mrst_tap_rti", tap_st, RTI);
        repeat (3) @(posedge tck); #1;
        chk("mrst_no_rsp", rsp_cnt, base_rsp);
        chk("mrst_tlr_seen", tlr_cnt > base_tlr, 1);
        chk("mrst_instr", ir, 7'h00);

        // DR loopback, L = 8
        base_sh = shdr_cnt;
        scan("dr8", 2'd2, 6'd8, 32'h0000_00A5, 14, 32'h0000_003C);
        chk("dr8_shift_cyc", shdr_cnt - base_sh, 8);
        chk("dr8_reg", dr_reg, 8'hA5);

        // length clamp: 0 -> 1 bit
        base_sh = shdr_cnt;
        scan("len0", 2'd2, 6'd0, 32'hFFFF_FFFE, 7, 32'h0000_0001);
        chk("len0_shift_cyc", shdr_cnt - base_sh, 1);
        chk("len0_reg", dr_reg, 8'h52);

        // length clamp: 63 -> 32 bits
        base_sh = shdr_cnt;
        scan("len63", 2'd2, 6'd63, 32'h1234_5678, 38, 32'h3456_7852);
        chk("len63_shift_cyc", shdr_cnt - base_sh, 32);
        chk("len63_reg", dr_reg, 8'h12);

        // reserved opcode behaves as TAP_RESET with a zero response
        base_tlr = tlr_cnt;
        run_cmd(2'd3, 6'd5, 32'hFFFF_FFFF, lat, rd);
        chk("op3_rsp_seen", lat > 0, 1);
        chk("op3_rsp_data", rd, 32'h0);
        chk("op3_tlr_seen", tlr_cnt > base_tlr, 1);
        chk("op3_tap_rti", tap_st, RTI);
        chk("op3_ready", cmd_ready, 1);
        @(posedge tck); #1;
        chk("op3_pulse", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
